// File: rtl/proc_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB, retires
// instructions into pc_in/instr_count and halts on illegal opcodes or memory timeouts.
module proc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic [31:0] pc_next,
  output logic        mem_enable,
  output logic        ir_load,
  output logic        reg_rd,
  output logic        alu_en,
  output logic        mem_req,
  output logic        reg_wr,
  output logic [31:0] pc_in,
  output logic        busy,
  output logic [2:0]  state,
  output logic [1:0]  err,
  output logic [31:0] instr_count
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t            state_q;
  state_t            nxt_state;
  logic [1:0]        nxt_err;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] nxt_wait;
  logic              retire;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  // Next-state, error and MEM wait-counter decisions
  always_comb begin
    nxt_state = state_q;
    nxt_err   = err;
    nxt_wait  = wait_cnt;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:   if (start) nxt_state = S_FETCH;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        if (is_legal(opcode)) begin
          nxt_state = S_EXEC;
        end else begin
          nxt_state = S_HALT;
          nxt_err   = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        nxt_state = ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? S_MEM : S_WB;
        nxt_wait  = '0;
      end
      S_MEM: begin
        if (mem_ready) begin
          nxt_state = S_WB;
          nxt_wait  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt_state = S_HALT;
          nxt_err   = ERR_TIMEOUT;
          nxt_wait  = '0;
        end else begin
          nxt_wait = wait_cnt + WAIT_W'(1);
        end
      end
      S_WB: begin
        retire    = 1'b1;
        nxt_state = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          nxt_state = S_FETCH;
          nxt_err   = ERR_NONE;
        end
      end
      default: begin
        nxt_state = S_HALT;
        nxt_err   = ERR_ILLEGAL;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      err         <= ERR_NONE;
      wait_cnt    <= '0;
      pc_in       <= RESET_PC;
      instr_count <= '0;
      mem_enable  <= 1'b0;
      ir_load     <= 1'b0;
      reg_rd      <= 1'b0;
      alu_en      <= 1'b0;
      mem_req     <= 1'b0;
      reg_wr      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q  <= nxt_state;
      err      <= nxt_err;
      wait_cnt <= nxt_wait;
      if (retire) begin
        pc_in       <= pc_next;
        instr_count <= instr_count + 32'd1;
      end
      mem_enable <= (nxt_state == S_FETCH);
      ir_load    <= (nxt_state == S_FETCH);
      reg_rd     <= (nxt_state == S_DECODE);
      alu_en     <= (nxt_state == S_EXEC);
      mem_req    <= (nxt_state == S_MEM);
      reg_wr     <= (nxt_state == S_WB) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
      busy       <= (nxt_state != S_IDLE) && (nxt_state != S_HALT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: per-cycle state/strobe model plus a
// retire scoreboard of expected pc_in/instr_count values.
module tb_proc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
  } retire_t;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        halt_req;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic [31:0] pc_next;
  logic        mem_enable;
  logic        ir_load;
  logic        reg_rd;
  logic        alu_en;
  logic        mem_req;
  logic        reg_wr;
  logic [31:0] pc_in;
  logic        busy;
  logic [2:0]  state;
  logic [1:0]  err;
  logic [31:0] instr_count;
  logic [5:0]  strobes;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  retire_t     sb[$];

  proc_sequencer #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .opcode(opcode), .mem_ready(mem_ready), .pc_next(pc_next),
    .mem_enable(mem_enable), .ir_load(ir_load), .reg_rd(reg_rd), .alu_en(alu_en),
    .mem_req(mem_req), .reg_wr(reg_wr), .pc_in(pc_in), .busy(busy), .state(state),
    .err(err), .instr_count(instr_count)
  );

  assign strobes = {mem_enable, ir_load, reg_rd, alu_en, mem_req, reg_wr};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // halt_mode: 0 = no halt, 1 = halt_req held throughout, 2 = halt_req pulsed only in EXEC
  task automatic exec_instr(input logic [6:0] op, input logic [31:0] pcn, input int waits,
                            input int halt_mode, input bit running, input int exp_cycles);
    logic [2:0] exp_st;
    logic [5:0] exp_strb;
    int         cyc;
    int         mcyc;
    bit         done;
    bit         is_mem;
    retire_t    want;
    cyc = 0; mcyc = 0; done = 1'b0; exp_st = S_FETCH;
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
    opcode = op; pc_next = pcn; halt_req = (halt_mode == 1); start = 1'b1;
    sb.push_back('{pc: pcn, cnt: exp_cnt + 32'd1});
    exp_cnt = exp_cnt + 32'd1;
    exp_pc  = pcn;
    if (!running) @(negedge clock);
    while (!done && cyc < 64) begin
      cyc++;
      mem_ready = 1'b1;
      if (exp_st != S_EXEC) halt_req = (halt_mode == 1);
      case (exp_st)
        S_FETCH:  exp_strb = 6'b110000;
        S_DECODE: exp_strb = 6'b001000;
        S_EXEC: begin
          exp_strb = 6'b000100;
          halt_req = (halt_mode != 0);
        end
        S_MEM: begin
          exp_strb  = 6'b000010;
          mcyc++;
          mem_ready = (mcyc > waits);
        end
        default: begin
          exp_strb = {5'b00000, (op != OP_STORE) && (op != OP_BRANCH)};
          done     = 1'b1;
        end
      endcase
      n_checks++;
      if (state !== exp_st) begin
        n_fail++;
        $display("FAIL seq op=%b cyc=%0d: state=%0d expected %0d", op, cyc, state, exp_st);
      end
      n_checks++;
      if (strobes !== exp_strb || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL strobes op=%b cyc=%0d: strobes=%b busy=%b expected %b busy=1",
                 op, cyc, strobes, busy, exp_strb);
      end
      case (exp_st)
        S_FETCH:  exp_st = S_DECODE;
        S_DECODE: exp_st = S_EXEC;
        S_EXEC:   exp_st = is_mem ? S_MEM : S_WB;
        S_MEM:    if (mem_ready) exp_st = S_WB;
        default:  ;
      endcase
      @(negedge clock);
    end
    start = 1'b0; mem_ready = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL wb_timeout op=%b: no WB within %0d cycles", op, cyc);
    end
    n_checks++;
    if (cyc != exp_cycles) begin
      n_fail++;
      $display("FAIL latency op=%b: %0d cycles expected %0d", op, cyc, exp_cycles);
    end
    want = sb.pop_front();
    n_checks++;
    if (pc_in !== want.pc || instr_count !== want.cnt) begin
      n_fail++;
      $display("FAIL retire op=%b: pc_in=%h count=%h expected pc_in=%h count=%h",
               op, pc_in, instr_count, want.pc, want.cnt);
    end
    n_checks++;
    if (state !== ((halt_mode == 1) ? S_HALT : S_FETCH) || busy !== (halt_mode != 1)) begin
      n_fail++;
      $display("FAIL wb_exit op=%b mode=%0d: state=%0d busy=%b", op, halt_mode, state, busy);
    end
    halt_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; halt_req = 1'b0; opcode = '0; mem_ready = 1'b0; pc_next = '0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (state !== S_IDLE || busy !== 1'b0 || err !== 2'd0 || strobes !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: state=%0d busy=%b err=%0d strobes=%b expected 0", state, busy, err, strobes);
    end
    n_checks++;
    if (pc_in !== RESET_PC || instr_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: pc_in=%h count=%h expected %h 0", pc_in, instr_count, RESET_PC);
    end
    start = 1'b0; reset_n = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (state !== S_IDLE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: state=%0d busy=%b expected IDLE without start", state, busy);
    end
  endtask

  task automatic test_alu();
    exec_instr(OP_RTYPE, 32'd4, 0, 0, 1'b0, 4);
    exec_instr(OP_ITYPE, 32'd8, 0, 1, 1'b1, 4);
  endtask

  task automatic test_load_store();
    exec_instr(OP_LOAD,   32'h100, 3, 1, 1'b0, 8);
    exec_instr(OP_STORE,  32'h104, 0, 1, 1'b0, 5);
    exec_instr(OP_BRANCH, 32'h108, 0, 1, 1'b0, 4);
    exec_instr(OP_LOAD,   32'h10c, 7, 1, 1'b0, 12);
  endtask

  task automatic test_opcodes();
    logic [6:0] ops[4];
    ops = '{OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int i = 0; i < 4; i++) exec_instr(ops[i], 32'h200 + 32'(i * 4), 0, 1, 1'b0, 4);
  endtask

  task automatic test_halt();
    exec_instr(OP_RTYPE, 32'h300, 0, 2, 1'b0, 4);
    exec_instr(OP_LOAD,  32'h304, 1, 2, 1'b1, 6);
    exec_instr(OP_RTYPE, 32'h308, 0, 1, 1'b1, 4);
  endtask

  task automatic test_illegal();
    opcode = 7'b0000000; start = 1'b1; mem_ready = 1'b0; halt_req = 1'b0; pc_next = 32'hdead_beef;
    @(negedge clock);
    start = 1'b0;
    n_checks++;
    if (state !== S_FETCH) begin
      n_fail++;
      $display("FAIL illegal_fetch: state=%0d expected %0d", state, S_FETCH);
    end
    @(negedge clock);
    n_checks++;
    if (state !== S_DECODE || reg_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_decode: state=%0d reg_rd=%b expected 2 1", state, reg_rd);
    end
    @(negedge clock);
    n_checks++;
    if (state !== S_HALT || err !== 2'd1 || alu_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_halt: state=%0d err=%0d alu_en=%b busy=%b expected 6 1 0 0",
               state, err, alu_en, busy);
    end
    n_checks++;
    if (pc_in !== exp_pc || instr_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL illegal_hold: pc_in=%h count=%h expected %h %h", pc_in, instr_count, exp_pc, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int mcyc;
    opcode = OP_STORE; start = 1'b1; mem_ready = 1'b0; halt_req = 1'b0; pc_next = 32'hbad0_0000;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (state !== S_MEM && cyc < 10) begin
      cyc++;
      @(negedge clock);
    end
    mcyc = 0;
    while (state === S_MEM && mcyc < 40) begin
      mcyc++;
      @(negedge clock);
    end
    n_checks++;
    if (mcyc != 15) begin
      n_fail++;
      $display("FAIL timeout_len: %0d MEM cycles expected 15", mcyc);
    end
    n_checks++;
    if (state !== S_HALT || err !== 2'd2 || mem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_halt: state=%0d err=%0d mem_req=%b busy=%b expected 6 2 0 0",
               state, err, mem_req, busy);
    end
    n_checks++;
    if (pc_in !== exp_pc || instr_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL timeout_hold: pc_in=%h count=%h expected %h %h", pc_in, instr_count, exp_pc, exp_cnt);
    end
    start = 1'b1;
    @(negedge clock);
    n_checks++;
    if (state !== S_FETCH || err !== 2'd0) begin
      n_fail++;
      $display("FAIL restart: state=%0d err=%0d expected 1 0", state, err);
    end
    exec_instr(OP_RTYPE, 32'h400, 0, 1, 1'b1, 4);
  endtask

  task automatic test_wrap();
    @(negedge clock);
    force dut.instr_count = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.instr_count;
    exp_cnt = 32'hFFFF_FFFF;
    exec_instr(OP_LUI, 32'h500, 0, 1, 1'b0, 4);
  endtask

  task automatic test_reset_mid();
    int cyc;
    opcode = OP_LOAD; start = 1'b1; mem_ready = 1'b0; halt_req = 1'b0; pc_next = 32'h600;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (state !== S_MEM && cyc < 10) begin
      cyc++;
      @(negedge clock);
    end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (state !== S_IDLE || mem_req !== 1'b0 || reg_wr !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl: state=%0d mem_req=%b reg_wr=%b busy=%b expected 0",
               state, mem_req, reg_wr, busy);
    end
    n_checks++;
    if (pc_in !== RESET_PC || instr_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_regs: pc_in=%h count=%h expected %h 0", pc_in, instr_count, RESET_PC);
    end
    @(negedge clock);
    reset_n = 1'b1;
    exp_pc = RESET_PC; exp_cnt = 32'd0;
    sb.delete();
    exec_instr(OP_RTYPE, 32'h40, 0, 1, 1'b0, 4);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; exp_pc = RESET_PC; exp_cnt = 32'd0;
    test_reset();
    test_alu();
    test_load_store();
    test_opcodes();
    test_halt();
    test_illegal();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: value loaded into pc_in on reset.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum MEM-state wait cycles before a timeout error, range 1..255.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; begins or resumes execution from IDLE or HALT.
REQ-006 halt_req  input  1  level; request to stop after the current instruction retires.
REQ-007 opcode  input  7  instr[6:0] of the fetched instruction, valid from the DECODE state onward.
REQ-008 mem_ready  input  1  data memory completion for the current mem_req.
REQ-009 pc_next  input  32  next PC from the datapath, valid in WB.
REQ-010 mem_enable  output  1  instruction-memory enable.
REQ-011 ir_load  output  1  instruction-register capture strobe.
REQ-012 reg_rd  output  1  register-file read strobe.
REQ-013 alu_en  output  1  ALU evaluate strobe.
REQ-014 mem_req  output  1  data-memory request, held until accepted.
REQ-015 reg_wr  output  1  register-file write strobe.
REQ-016 pc_in  output  32  registered program counter driven to the datapath.
REQ-017 busy  output  1  high in the FETCH, DECODE, EXEC, MEM and WB states.
REQ-018 state  output  3  current state encoding.
REQ-019 err  output  2  0 = none, 1 = illegal opcode, 2 = memory timeout.
REQ-020 instr_count  output  32  count of retired instructions.

Function
REQ-021 State encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; encoding 7 SHALL go to HALT with err=1.
REQ-022 All strobe outputs SHALL be registered Moore outputs of the state, except the reg_wr qualification by opcode defined in REQ-029.
REQ-023 IDLE: with start=1 the next state SHALL be FETCH; otherwise the block stays in IDLE.
REQ-024 FETCH: the block SHALL assert mem_enable=1 and ir_load=1 for exactly 1 cycle, then go to DECODE.
REQ-025 DECODE: the block SHALL assert reg_rd=1. The legal opcode set is 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. A legal opcode SHALL go to EXEC; any other opcode SHALL go to HALT with err=1.
REQ-026 EXEC: the block SHALL assert alu_en=1. Load (0000011) or store (0100011) SHALL go to MEM; every other opcode SHALL go to WB.
REQ-027 MEM: the block SHALL hold mem_req=1 and count wait cycles. On mem_ready=1 the next state SHALL be WB and the wait counter SHALL clear.
REQ-028 MEM timeout: if mem_ready is still 0 when the wait counter reaches MEM_TIMEOUT, the next state SHALL be HALT with err=2.
REQ-029 WB: reg_wr=1 SHALL be asserted only when the opcode is not store (0100011) and not branch (1100011).
REQ-030 The WB cycle SHALL be the retire cycle:
- pc_in SHALL load pc_next.
- instr_count SHALL increment modulo 2^32 (wrapping from FFFF_FFFF to 0).
REQ-031 WB exit: if halt_req=1 in WB the next state SHALL be HALT; otherwise it SHALL be FETCH.
REQ-032 halt_req SHALL be ignored in every state other than WB.
REQ-033 Latency: a non-memory instruction SHALL take 4 cycles (FETCH, DECODE, EXEC, WB). A memory instruction SHALL take 5+N cycles, where N is the number of mem_ready=0 cycles in MEM.
REQ-034 HALT: busy=0 and all strobes SHALL be 0; pc_in and instr_count SHALL hold.
REQ-035 HALT exit: start=1 SHALL go to FETCH and clear err to 0.
REQ-036 Error exits (REQ-025, REQ-028) SHALL NOT update pc_in or instr_count.
REQ-037 mem_ready arriving outside the MEM state SHALL be ignored.
REQ-038 start asserted while busy=1 SHALL be ignored.

Reset
REQ-039 While reset_n=0, regardless of clock, the block SHALL be in IDLE with:
- pc_in=RESET_PC, instr_count=0, err=0, busy=0;
- all strobes at 0 and the wait counter at 0.
REQ-040 A reset asserted mid-instruction, including in MEM, SHALL abandon that instruction immediately, with no retire and no reg_wr.
REQ-041 The first state transition after reset_n rises SHALL occur on the first clock edge on which start=1.

Verification
REQ-042 Reset then start=1 with opcode=0110011 and pc_next=4 -> states 1,2,3,5 on successive cycles; reg_wr=1 in WB; then pc_in=4, instr_count=1, state=1.
REQ-043 Load opcode=0000011 with mem_ready low for 3 cycles -> mem_req high 4 cycles; WB reg_wr=1; 8 cycles total; instr_count increments by 1.
REQ-044 Store opcode=0100011 with mem_ready never asserted and MEM_TIMEOUT=15 -> HALT after 15 MEM cycles; err=2; pc_in unchanged; start then clears err and enters FETCH.
REQ-045 opcode=0000000 in DECODE -> state=6, err=1, no alu_en, pc_in unchanged.
REQ-046 halt_req=1 in EXEC and held through WB -> the instruction retires, then state=6, busy=0; a halt_req pulse only in EXEC -> the instruction retires and the block continues to FETCH.
REQ-047 instr_count forced to FFFF_FFFF, then one retire -> instr_count=0; reset_n pulsed low during MEM -> immediately state=0, pc_in=RESET_PC, mem_req=0.
